multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer_if.sv | 30 +++
 rtl/multicycle_sequencer.sv | 166 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multicycle sequencer and its datapath/memory.
interface multicycle_sequencer_if;
    logic       run;
    logic [5:0] opcode;
    logic       memReady;
    logic [2:0] state;
    logic       irWrite;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       branchEn;
    logic       memRead;
    logic       memWrite;
    logic       iorD;
    logic       byteOp;
    logic       regWrite;
    logic       instrDone;
    logic       illegalOp;

    modport master (
        input  run, opcode, memReady,
        output state, irWrite, pcWrite, pcSrc, branchEn, memRead, memWrite,
               iorD, byteOp, regWrite, instrDone, illegalOp
    );

    modport slave (
        output run, opcode, memReady,
        input  state, irWrite, pcWrite, pcSrc, branchEn, memRead, memWrite,
               iorD, byteOp, regWrite, instrDone, illegalOp
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB control sequencer for a multicycle CPU.
// Strobes are decoded from the registered state plus memReady so memory handshakes complete in-cycle.
module multicycle_sequencer (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_JAL, C_ILLEGAL
    } op_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_SUBI  = 6'b000011;
    localparam logic [5:0] OP_ANDI  = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b000101;
    localparam logic [5:0] OP_SLTI  = 6'b000111;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b001001;
    localparam logic [5:0] OP_SW    = 6'b010000;
    localparam logic [5:0] OP_SB    = 6'b010001;
    localparam logic [5:0] OP_MOVE  = 6'b100000;
    localparam logic [5:0] OP_BEQ   = 6'b100011;
    localparam logic [5:0] OP_BNE   = 6'b100111;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JAL   = 6'b111001;

    function automatic op_class_t classify(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_SUBI, OP_ANDI,
            OP_ORI, OP_SLTI, OP_MOVE:            return C_ALU;
            OP_LW, OP_LB:                        return C_LOAD;
            OP_SW, OP_SB:                        return C_STORE;
            OP_BEQ, OP_BNE:                      return C_BRANCH;
            OP_J:                                return C_JUMP;
            OP_JAL:                              return C_JAL;
            default:                             return C_ILLEGAL;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [5:0] op_q;
    op_class_t  cls;
    logic       is_byte;

    logic       ir_write, pc_write, branch_en, mem_read, mem_write;
    logic       ior_d, byte_op, reg_write, instr_done, illegal_op;
    logic [1:0] pc_src;

    // State register and the opcode latch that holds the instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= 6'b000000;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= bus.opcode;
        end
    end

    assign cls     = classify(op_q);
    assign is_byte = (op_q == OP_LB) || (op_q == OP_SB);

    always_comb begin
        state_d    = state_q;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        branch_en  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ior_d      = 1'b0;
        byte_op    = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.run) begin
                    mem_read = 1'b1;
                    if (bus.memReady) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
            end
            // Legality uses the live opcode; the latch only captures it at this edge.
            S_DECODE: begin
                if (classify(bus.opcode) == C_ILLEGAL) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_ALU:            state_d = S_WB;
                    C_LOAD, C_STORE:  state_d = S_MEM;
                    C_BRANCH: begin
                        branch_en  = 1'b1;
                        pc_src     = 2'b01;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    C_JUMP: begin
                        pc_write   = 1'b1;
                        pc_src     = 2'b10;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    C_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        state_d  = S_WB;
                    end
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                ior_d     = 1'b1;
                byte_op   = is_byte;
                mem_read  = (cls == C_LOAD);
                mem_write = (cls == C_STORE);
                if (bus.memReady) begin
                    if (cls == C_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are forced low for the whole reset window, independent of clk.
    assign bus.state     = state_q;
    assign bus.irWrite   = rst_n & ir_write;
    assign bus.pcWrite   = rst_n & pc_write;
    assign bus.pcSrc     = rst_n ? pc_src : 2'b00;
    assign bus.branchEn  = rst_n & branch_en;
    assign bus.memRead   = rst_n & mem_read;
    assign bus.memWrite  = rst_n & mem_write;
    assign bus.iorD      = rst_n & ior_d;
    assign bus.byteOp    = rst_n & byte_op;
    assign bus.regWrite  = rst_n & reg_write;
    assign bus.instrDone = rst_n & instr_done;
    assign bus.illegalOp = rst_n & illegal_op;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed scoreboard bench: each stimulus cycle queues its expected output vector; a monitor compares.
module tb_multicycle_sequencer;
    typedef logic [14:0] vec_t;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    vec_t  exp_q[$];
    string name_q[$];

    multicycle_sequencer_if bus();

    multicycle_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // {state, irWrite, pcWrite, pcSrc, branchEn, memRead, memWrite, iorD, byteOp, regWrite, instrDone, illegalOp}
    function automatic vec_t mk(input logic [2:0] st, input logic ir, input logic pcw,
                                input logic [1:0] src, input logic br, input logic mr,
                                input logic mw, input logic io, input logic by,
                                input logic rw, input logic dn, input logic il);
        return {st, ir, pcw, src, br, mr, mw, io, by, rw, dn, il};
    endfunction

    function automatic vec_t actual();
        return {bus.state, bus.irWrite, bus.pcWrite, bus.pcSrc, bus.branchEn, bus.memRead,
                bus.memWrite, bus.iorD, bus.byteOp, bus.regWrite, bus.instrDone, bus.illegalOp};
    endfunction

    task automatic step(input logic rn, input logic r, input logic [5:0] op,
                        input logic mrdy, input vec_t e, input string n);
        @(posedge clk);
        #1;
        rst_n        = rn;
        bus.run      = r;
        bus.opcode   = op;
        bus.memReady = mrdy;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // Monitor: one expected vector per cycle, sampled mid-cycle.
    initial begin
        vec_t  e, a;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = actual();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", n, a, e);
                end
                checks++;
                if ((bus.memRead & bus.memWrite) || (bus.regWrite & bus.pcWrite)) begin
                    errors++;
                    $display("FAIL %s_exclusive: mr=%b mw=%b rw=%b pcw=%b expected no overlap",
                             n, bus.memRead, bus.memWrite, bus.regWrite, bus.pcWrite);
                end
            end
        end
    end

    initial begin
        vec_t zero_f, fe, fwait;
        zero_f = mk(F,0,0,2'b00,0,0,0,0,0,0,0,0);
        fe     = mk(F,1,1,2'b00,0,1,0,0,0,0,0,0);
        fwait  = mk(F,0,0,2'b00,0,1,0,0,0,0,0,0);
        bus.run = 1'b0; bus.opcode = 6'b0; bus.memReady = 1'b0;

        // Reset held with run and memReady high: everything quiet.
        step(0, 1, 6'b000000, 1, zero_f, "reset0");
        step(0, 1, 6'b000000, 1, zero_f, "reset1");

        // addi: 4 cycles, opcode changed after DECODE must not matter.
        step(1, 1, 6'b000000, 1, fe, "addi_fetch");
        step(1, 1, 6'b000010, 1, mk(D,0,0,2'b00,0,0,0,0,0,0,0,0), "addi_decode");
        step(1, 1, 6'b111000, 1, mk(E,0,0,2'b00,0,0,0,0,0,0,0,0), "addi_exec");
        step(1, 1, 6'b111000, 1, mk(W,0,0,2'b00,0,0,0,0,0,1,1,0), "addi_wb");

        // lw with two MEM wait cycles: 7 cycles total.
        step(1, 1, 6'b000000, 1, fe, "lw_fetch");
        step(1, 1, 6'b001000, 1, mk(D,0,0,2'b00,0,0,0,0,0,0,0,0), "lw_decode");
        step(1, 1, 6'b001000, 0, mk(E,0,0,2'b00,0,0,0,0,0,0,0,0), "lw_exec");
        step(1, 1, 6'b001000, 0, mk(M,0,0,2'b00,0,1,0,1,0,0,0,0), "lw_mem_wait0");
        step(1, 1, 6'b001000, 0, mk(M,0,0,2'b00,0,1,0,1,0,0,0,0), "lw_mem_wait1");
        step(1, 1, 6'b001000, 1, mk(M,0,0,2'b00,0,1,0,1,0,0,0,0), "lw_mem_ready");
        step(1, 1, 6'b001000, 1, mk(W,0,0,2'b00,0,0,0,0,0,1,1,0), "lw_wb");

        // sb: store byte completes in MEM.
        step(1, 1, 6'b000000, 1, fe, "sb_fetch");
        step(1, 1, 6'b010001, 1, mk(D,0,0,2'b00,0,0,0,0,0,0,0,0), "sb_decode");
        step(1, 1, 6'b010001, 1, mk(E,0,0,2'b00,0,0,0,0,0,0,0,0), "sb_exec");
        step(1, 1, 6'b010001, 1, mk(M,0,0,2'b00,0,0,1,1,1,0,1,0), "sb_mem");

        // jal then j.
        step(1, 1, 6'b000000, 1, fe, "jal_fetch");
        step(1, 1, 6'b111001, 1, mk(D,0,0,2'b00,0,0,0,0,0,0,0,0), "jal_decode");
        step(1, 1, 6'b111001, 1, mk(E,0,1,2'b10,0,0,0,0,0,0,0,0), "jal_exec");
        step(1, 1, 6'b111001, 1, mk(W,0,0,2'b00,0,0,0,0,0,1,1,0), "jal_wb");
        step(1, 1, 6'b000000, 1, fe, "j_fetch");
        step(1, 1, 6'b111000, 1, mk(D,0,0,2'b00,0,0,0,0,0,0,0,0), "j_decode");
        step(1, 1, 6'b111000, 1, mk(E,0,1,2'b10,0,0,0,0,0,0,1,0), "j_exec");

        // beq: branch qualified by the datapath.
        step(1, 1, 6'b000000, 1, fe, "beq_fetch");
        step(1, 1, 6'b100011, 1, mk(D,0,0,2'b00,0,0,0,0,0,0,0,0), "beq_decode");
        step(1, 1, 6'b100011, 1, mk(E,0,0,2'b01,1,0,0,0,0,0,1,0), "beq_exec");

        // Illegal opcode, then idle with run low.
        step(1, 1, 6'b000000, 1, fe, "ill_fetch");
        step(1, 1, 6'b111111, 1, mk(D,0,0,2'b00,0,0,0,0,0,0,1,1), "ill_decode");
        step(1, 0, 6'b111111, 1, zero_f, "idle_run0");

        // Fetch wait, then sw stalled in MEM and reset mid-access.
        step(1, 1, 6'b000000, 0, fwait, "sw_fetch_wait");
        step(1, 1, 6'b000000, 1, fe, "sw_fetch");
        step(1, 1, 6'b010000, 0, mk(D,0,0,2'b00,0,0,0,0,0,0,0,0), "sw_decode");
        step(1, 1, 6'b010000, 0, mk(E,0,0,2'b00,0,0,0,0,0,0,0,0), "sw_exec");
        step(1, 1, 6'b010000, 0, mk(M,0,0,2'b00,0,0,1,1,0,0,0,0), "sw_mem_wait");
        step(0, 1, 6'b010000, 0, zero_f, "sw_reset");
        step(1, 0, 6'b010000, 1, zero_f, "post_reset_idle0");
        step(1, 0, 6'b010000, 1, zero_f, "post_reset_idle1");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
